// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Single-port data memory target for a req/gnt/rvalid initiator interface.
// A request is granted either combinationally (GNT_WAIT = 0) or after
// GNT_WAIT idle cycles. Exactly one response (rvalid) follows each grant
// by one cycle. Misaligned or out-of-range addresses return an error
// response and never touch the memory.
//
// Parameters
//   DEPTH     number of 32-bit words (power of two, 4..256)
//   GNT_WAIT  idle cycles between request and grant (0..15)
//
// Ports
//   clock         single clock, rising edge
//   reset         asynchronous active-high reset; also clears the memory
//   data_req_i    initiator request valid
//   data_gnt_o    request accepted this cycle
//   data_addr_i   byte address
//   data_we_i     1 = write, 0 = read
//   data_be_i     byte enables, bit i covers data bits 8i+7..8i
//   data_wdata_i  write data
//   data_rvalid_o response valid, one cycle after each grant
//   data_rdata_o  read data, zero unless a valid read response
//   data_err_o    address error flag, valid with data_rvalid_o

module data_mem_responder #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned GNT_WAIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Counter preload; only meaningful when GNT_WAIT > 0.
    localparam logic [3:0] WAIT_LOAD = 4'(GNT_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic          addr_err;
    logic [AW-1:0] idx;
    logic          wr_ok;

    // Address decode: word aligned and inside the array.
    always_comb begin
        addr_err = (data_addr_i[1:0] != 2'b00) ||
                   (data_addr_i[31:2] >= 30'(DEPTH));
        idx      = data_addr_i[AW+1:2];
        wr_ok    = data_gnt_o && data_we_i && !addr_err;
    end

    // Grant: pass-through of the request when there is no wait, otherwise
    // only on the last WAIT cycle with the request still held. Reset masks
    // the grant immediately since the state flops alone would not.
    always_comb begin
        data_gnt_o = 1'b0;
        if (GNT_WAIT == 0) begin
            data_gnt_o = data_req_i && (state != WAIT);
        end else begin
            data_gnt_o = data_req_i && (state == WAIT) && (cnt == 4'd0);
        end
        if (reset) begin
            data_gnt_o = 1'b0;
        end
    end

    // Control FSM and registered response outputs. The response registers
    // are loaded from the grant, so they are non-zero only while in RESP.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
            data_err_o    <= 1'b0;
        end else begin
            data_rvalid_o <= data_gnt_o;
            data_err_o    <= data_gnt_o && addr_err;
            if (data_gnt_o && !data_we_i && !addr_err) begin
                data_rdata_o <= mem[idx];
            end else begin
                data_rdata_o <= '0;
            end

            case (state)
                IDLE: begin
                    if (GNT_WAIT == 0) begin
                        state <= data_gnt_o ? RESP : IDLE;
                    end else if (data_req_i) begin
                        cnt   <= WAIT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!data_req_i) begin
                        // Request withdrawn before grant: drop it silently.
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Zero-wait mode may chain grants back to back.
                    if (GNT_WAIT == 0) begin
                        state <= data_gnt_o ? RESP : IDLE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage with byte-enable writes, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//
// Directed bench for data_mem_responder. Two instances share clock and
// reset: dut0 with GNT_WAIT=0 and dut3 with GNT_WAIT=3, both DEPTH=64.

module tb_data_mem_responder;

    logic clock;
    logic reset;

    logic        req0, gnt0, we0, rvalid0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  be0;

    logic        req3, gnt3, we3, rvalid3, err3;
    logic [31:0] addr3, wdata3, rdata3;
    logic [3:0]  be3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    data_mem_responder #(.DEPTH(64), .GNT_WAIT(0)) dut0 (
        .clock        (clock),
        .reset        (reset),
        .data_req_i   (req0),
        .data_gnt_o   (gnt0),
        .data_addr_i  (addr0),
        .data_we_i    (we0),
        .data_be_i    (be0),
        .data_wdata_i (wdata0),
        .data_rvalid_o(rvalid0),
        .data_rdata_o (rdata0),
        .data_err_o   (err0)
    );

    data_mem_responder #(.DEPTH(64), .GNT_WAIT(3)) dut3 (
        .clock        (clock),
        .reset        (reset),
        .data_req_i   (req3),
        .data_gnt_o   (gnt3),
        .data_addr_i  (addr3),
        .data_we_i    (we3),
        .data_be_i    (be3),
        .data_wdata_i (wdata3),
        .data_rvalid_o(rvalid3),
        .data_rdata_o (rdata3),
        .data_err_o   (err3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int unsigned k);
        return {8'hA5, 8'(k), 8'(~k), 8'(k * 3)};
    endfunction

    // One zero-wait transaction followed by one idle cycle.
    task automatic txn0(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic exp_err,
                        input logic [31:0] exp_rd, input string name);
        @(negedge clock);
        req0 = 1'b1; we0 = we; addr0 = addr; be0 = be; wdata0 = wd;
        #1;
        chk($sformatf("%s gnt", name), 32'(gnt0), 32'd1);
        chk($sformatf("%s idle rvalid", name), 32'(rvalid0), 32'd0);
        @(negedge clock);
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0000_0004; be0 = 4'hF; wdata0 = 32'hFFFF_FFFF;
        #1;
        chk($sformatf("%s rvalid", name), 32'(rvalid0), 32'd1);
        chk($sformatf("%s rdata", name), rdata0, exp_rd);
        chk($sformatf("%s err", name), 32'(err0), 32'(exp_err));
        chk($sformatf("%s gnt low", name), 32'(gnt0), 32'd0);
    endtask

    // GNT_WAIT=3 transaction: misleading inputs while waiting, real ones
    // only in the grant cycle.
    task automatic txn3(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd, input string name);
        @(negedge clock);
        req3 = 1'b1; we3 = ~we; addr3 = addr ^ 32'h4; be3 = 4'hF; wdata3 = ~wd;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("%s wait gnt c%0d", name, c), 32'(gnt3), 32'd0);
            @(negedge clock);
        end
        we3 = we; addr3 = addr; wdata3 = wd;
        #1;
        chk($sformatf("%s gnt", name), 32'(gnt3), 32'd1);
        @(negedge clock);
        req3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0;
        #1;
        chk($sformatf("%s rvalid", name), 32'(rvalid3), 32'd1);
        chk($sformatf("%s rdata", name), rdata3, exp_rd);
        chk($sformatf("%s err", name), 32'(err3), 32'(exp_err));
        chk($sformatf("%s gnt low", name), 32'(gnt3), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, "wr10"};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, "rd10"};
        vecs[2]  = '{1'b1, 32'h0000_0010, 4'b0101, 32'h1122_3344, 1'b0, 32'h0000_0000, "wr10part"};
        vecs[3]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0000_0000, 1'b0, 32'hDE22_BE44, "rd10part"};
        vecs[4]  = '{1'b0, 32'h0000_0100, 4'b1111, 32'h0000_0000, 1'b1, 32'h0000_0000, "rd100err"};
        vecs[5]  = '{1'b1, 32'h0000_0012, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, "wr12err"};
        vecs[6]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0000_0000, 1'b0, 32'hDE22_BE44, "rd10after"};
        vecs[7]  = '{1'b1, 32'h0000_0014, 4'b0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, "wr14be0"};
        vecs[8]  = '{1'b0, 32'h0000_0014, 4'b1111, 32'h0000_0000, 1'b0, 32'h0000_0000, "rd14"};
        vecs[9]  = '{1'b1, 32'h0000_00FC, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, "wrFC"};
        vecs[10] = '{1'b0, 32'h0000_00FC, 4'b1111, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, "rdFC"};
        vecs[11] = '{1'b0, 32'h0000_0101, 4'b1111, 32'h0000_0000, 1'b1, 32'h0000_0000, "rd101err"};
        vecs[12] = '{1'b1, 32'h0000_0000, 4'b1000, 32'hA5FF_FFFF, 1'b0, 32'h0000_0000, "wr0b3"};
        vecs[13] = '{1'b1, 32'h0000_0100, 4'b1111, 32'h1234_5678, 1'b1, 32'h0000_0000, "wr100err"};
        vecs[14] = '{1'b0, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b0, 32'hA500_0000, "rd0"};
        vecs[15] = '{1'b0, 32'h8000_0010, 4'b1111, 32'h0000_0000, 1'b1, 32'h0000_0000, "rdhigh"};

        req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
        req3 = 1'b0; we3 = 1'b0; addr3 = '0; be3 = '0; wdata3 = '0;
        reset = 1'b1;

        // Reset state, including grant masked while a request is present.
        repeat (2) @(negedge clock);
        req0 = 1'b1; req3 = 1'b1;
        #1;
        chk("rst gnt0", 32'(gnt0), 32'd0);
        chk("rst rvalid0", 32'(rvalid0), 32'd0);
        chk("rst rdata0", rdata0, 32'd0);
        chk("rst err0", 32'(err0), 32'd0);
        chk("rst gnt3", 32'(gnt3), 32'd0);
        chk("rst rvalid3", 32'(rvalid3), 32'd0);
        req0 = 1'b0; req3 = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Table-driven single transactions on the zero-wait instance.
        for (int i = 0; i < 16; i++) begin
            txn0(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                 vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].name);
        end

        // Back-to-back writes to all words, then back-to-back reads from
        // the top down so word 63 is read right after being written.
        @(negedge clock);
        for (int k = 0; k < 64; k++) begin
            req0 = 1'b1; we0 = 1'b1; addr0 = 32'(k * 4); be0 = 4'hF; wdata0 = pat(k);
            #1;
            chk($sformatf("b2b wr%0d gnt", k), 32'(gnt0), 32'd1);
            if (k > 0) begin
                chk($sformatf("b2b wr%0d rvalid", k), 32'(rvalid0), 32'd1);
                chk($sformatf("b2b wr%0d err", k), 32'(err0), 32'd0);
            end
            @(negedge clock);
        end
        for (int k = 0; k < 64; k++) begin
            req0 = 1'b1; we0 = 1'b0; addr0 = 32'((63 - k) * 4); be0 = 4'h0; wdata0 = 32'hFFFF_FFFF;
            #1;
            chk($sformatf("b2b rd%0d gnt", k), 32'(gnt0), 32'd1);
            chk($sformatf("b2b rd%0d rvalid", k), 32'(rvalid0), 32'd1);
            if (k == 0) begin
                chk("b2b rd0 wresp rdata", rdata0, 32'd0);
            end else begin
                chk($sformatf("b2b rd%0d rdata", k), rdata0, pat(64 - k));
            end
            @(negedge clock);
        end
        req0 = 1'b0;
        #1;
        chk("b2b last rvalid", 32'(rvalid0), 32'd1);
        chk("b2b last rdata", rdata0, pat(0));
        @(negedge clock);
        #1;
        chk("b2b end rvalid", 32'(rvalid0), 32'd0);
        chk("b2b end rdata", rdata0, 32'd0);

        // Reset during RESP of a write to 0x20.
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; be0 = 4'hF; wdata0 = 32'h1357_9BDF;
        #1;
        chk("rstresp gnt", 32'(gnt0), 32'd1);
        @(posedge clock);
        #1;
        req0 = 1'b0; we0 = 1'b0;
        chk("rstresp rvalid before", 32'(rvalid0), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstresp rvalid", 32'(rvalid0), 32'd0);
        chk("rstresp rdata", rdata0, 32'd0);
        chk("rstresp err", 32'(err0), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rstresp after rvalid", 32'(rvalid0), 32'd0);
        txn0(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'h0, "rd20 after rst");
        txn0(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'h0, "rd10 after rst");

        // GNT_WAIT=3 timing with the request held continuously.
        @(negedge clock);
        req3 = 1'b1; we3 = 1'b0; addr3 = 32'h10; be3 = 4'hF;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("gw3 c%0d gnt", c), 32'(gnt3), 32'((c == 3) || (c == 8)));
            chk($sformatf("gw3 c%0d rvalid", c), 32'(rvalid3), 32'((c == 4) || (c == 9)));
            if ((c == 4) || (c == 9)) begin
                chk($sformatf("gw3 c%0d rdata", c), rdata3, 32'd0);
                chk($sformatf("gw3 c%0d err", c), 32'(err3), 32'd0);
            end
            @(negedge clock);
        end
        req3 = 1'b0;
        @(negedge clock);

        // Inputs sampled only in the grant cycle.
        txn3(1'b1, 32'h8, 32'h55AA_33CC, 1'b0, 32'h0, "gw3 wr8");
        txn3(1'b0, 32'h8, 32'h0, 1'b0, 32'h55AA_33CC, "gw3 rd8");
        txn3(1'b0, 32'hC, 32'h0, 1'b0, 32'h0, "gw3 rdC");
        txn3(1'b0, 32'h100, 32'h0, 1'b1, 32'h0, "gw3 rd100err");

        // Request withdrawn while waiting: no grant, no response.
        @(negedge clock);
        req3 = 1'b1; we3 = 1'b0; addr3 = 32'h8;
        @(negedge clock);
        @(negedge clock);
        req3 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("drop c%0d gnt", c), 32'(gnt3), 32'd0);
            chk($sformatf("drop c%0d rvalid", c), 32'(rvalid3), 32'd0);
            @(negedge clock);
        end

        // Reset while waiting: request discarded.
        req3 = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1; req3 = 1'b0;
        #1;
        chk("rstwait gnt", 32'(gnt3), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rstwait c%0d gnt", c), 32'(gnt3), 32'd0);
            chk($sformatf("rstwait c%0d rvalid", c), 32'(rvalid3), 32'd0);
            @(negedge clock);
        end

        // First grant after release keeps full wait timing; memory cleared.
        txn3(1'b0, 32'h8, 32'h0, 1'b0, 32'h0, "gw3 rd8 after rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words (power of two, 4..256).
REQ-002 SHALL have parameter GNT_WAIT, default 0, idle cycles between request and grant (0..15).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port data_req_i  input  1  initiator request valid.
REQ-006 SHALL have port data_gnt_o  output  1  request accepted this cycle.
REQ-007 SHALL have port data_addr_i  input  32  byte address.
REQ-008 SHALL have port data_we_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port data_be_i  input  4  byte enables; bit i covers bits 8i+7..8i.
REQ-010 SHALL have port data_wdata_i  input  32  write data.
REQ-011 SHALL have port data_rvalid_o  output  1  response valid, one cycle per granted request.
REQ-012 SHALL have port data_rdata_o  output  32  read data, valid with data_rvalid_o.
REQ-013 SHALL have port data_err_o  output  1  error flag, valid with data_rvalid_o.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-015 GNT_WAIT=0: in IDLE or RESP, data_gnt_o = data_req_i (combinational); a grant enters RESP, otherwise IDLE.
REQ-016 GNT_WAIT>0: IDLE with data_req_i=1 loads counter with GNT_WAIT-1 and enters WAIT; data_gnt_o=0 in IDLE.
REQ-017 In WAIT, counter decrements each cycle; data_gnt_o=1 when counter is 0, then next state RESP; grant thus in cycle GNT_WAIT after request rise.
REQ-018 GNT_WAIT>0: in RESP, data_gnt_o=0; RESP always returns to IDLE after one cycle.
REQ-019 data_req_i deasserted in WAIT (protocol violation) SHALL return to IDLE without grant or response.
REQ-020 data_rvalid_o SHALL be 1 exactly in the cycle after each grant (RESP state), never otherwise; at most one response outstanding.
REQ-021 Address error: addr[1:0]!=0 or addr[31:2] >= DEPTH; error SHALL yield data_err_o=1, data_rdata_o=0, no memory change.
REQ-022 Valid write: on the grant edge, each byte with data_be_i[i]=1 SHALL be updated from data_wdata_i; response rdata=0, err=0.
REQ-023 Valid read: word at addr[31:2] sampled on the grant edge SHALL appear on data_rdata_o in RESP with err=0; data_be_i ignored.
REQ-024 Write followed by back-to-back read of same word SHALL return the written data.
REQ-025 Write with data_be_i=0000 SHALL complete normally with memory unchanged.
REQ-026 Outside RESP, data_rdata_o and data_err_o SHALL be 0.
REQ-027 Address, we, be, wdata SHALL be sampled only in the grant cycle.

Reset
REQ-028 reset=1 SHALL immediately force state IDLE, counter 0, data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0.
REQ-029 reset SHALL clear all memory words to 0x00000000.
REQ-030 Reset asserted in WAIT or RESP SHALL discard the pending request/response; no rvalid after release.
REQ-031 First grant after reset release SHALL follow REQ-015..017 timing from the first sampled data_req_i=1.

Verification
REQ-032 GNT_WAIT=0: write 0x0000_0010 data 0xDEADBEEF be 1111, then read 0x10 -> gnt same cycles, rvalid next cycles, rdata 0xDEADBEEF, err 0.
REQ-033 Partial write: after REQ-032, write 0x10 data 0x1122_3344 be 0101 then read -> rdata 0xDE22BE44.
REQ-034 GNT_WAIT=3: req held from cycle 0 -> gnt only in cycle 3, rvalid only in cycle 4, next grant no earlier than cycle 8.
REQ-035 Errors, DEPTH=64: read 0x100 and write 0x12 -> rvalid with err 1, rdata 0; subsequent read 0x10 unchanged.
REQ-036 Reset during RESP after write to 0x20 -> rvalid low, read of 0x20 after release returns 0x00000000.
REQ-037 Continuous back-to-back reads with GNT_WAIT=0 over words 0..63 -> one rvalid per grant, each one cycle later, data matching prior writes.
